freq_meas_sequencer: RTL and testbench

Measurement sequencer for the frequency-counter datapath. Sequences each measurement cycle: clears the BCD counter, opens the gate for a fixed number of reference-clock cycles, then waits for the counter to settle. It then latches the digit vector plus an overflow flag and hands the result to the OLED data streamer through its write/ready handshake. Sits between `counter_bcd_Ndigits` and `data_streamer`, replacing the free-running divider tap that currently gates the counter.

---
 rtl/freq_meas_pkg.sv | 28 ++
 rtl/freq_meas_sequencer.sv | 160 ++++++++++++++++
 tb/tb_freq_meas_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-measurement sequencer.
package freq_meas_pkg;

  // Measurement phases, in the order a normal cycle walks through them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_GATE    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_LATCH   = 3'd4,
    ST_SEND    = 3'd5,
    ST_HOLDOFF = 3'd6
  } meas_state_t;

  // Digit value shown on every position when the counter has overflowed.
  localparam logic [3:0] BCD_NINE = 4'h9;

  // Largest of four cycle counts; sizes the shared phase timer.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/freq_meas_sequencer.sv
// Measurement sequencer: clear -> gate -> settle -> latch -> send -> holdoff.
// Drives the BCD counter's clear/gate lines and hands each latched result
// (digits plus overflow flag) to the display streamer.
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter int DIGITS_NUM     = 6,
  parameter int GATE_CYCLES    = 1000000,
  parameter int CLEAR_CYCLES   = 2,
  parameter int SETTLE_CYCLES  = 3,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    run_in,
  input  logic                    single_stb_in,
  input  logic [4*DIGITS_NUM-1:0] cnt_digits_in,
  input  logic                    cnt_carry_in,
  input  logic                    ready_in,
  output logic                    cnt_reset,
  output logic                    cnt_enable,
  output logic [4*DIGITS_NUM-1:0] digits_out,
  output logic                    overflow,
  output logic                    write_stb,
  output logic                    busy
);

  localparam int DW      = 4 * DIGITS_NUM;
  localparam int MAX_CYC = max_of4(GATE_CYCLES, CLEAR_CYCLES, SETTLE_CYCLES, HOLDOFF_CYCLES);
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  // Timer reload values: each timed phase lasts (load + 1) cycles.
  localparam logic [TMR_W-1:0] CLEAR_LD  = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  meas_state_t      state;
  logic [TMR_W-1:0] tmr;
  logic             sticky_ovf;

  // An overflowed count is meaningless, so the display shows all nines.
  function automatic logic [DW-1:0] sat_digits(input logic [DW-1:0] digits, input logic ovf);
    if (ovf) return {DIGITS_NUM{BCD_NINE}};
    return digits;
  endfunction

  // Sequencer FSM; every output is registered and set on the transition
  // into the phase that needs it.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state      <= ST_IDLE;
      tmr        <= '0;
      sticky_ovf <= 1'b0;
      cnt_reset  <= 1'b1;
      cnt_enable <= 1'b0;
      digits_out <= '0;
      overflow   <= 1'b0;
      write_stb  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      write_stb <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt_reset <= 1'b1;
          if (run_in || single_stb_in) begin
            state      <= ST_CLEAR;
            tmr        <= CLEAR_LD;
            sticky_ovf <= 1'b0;
            busy       <= 1'b1;
          end
        end

        ST_CLEAR: begin
          if (tmr == '0) begin
            state      <= ST_GATE;
            tmr        <= GATE_LD;
            cnt_reset  <= 1'b0;
            cnt_enable <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_GATE: begin
          sticky_ovf <= sticky_ovf | cnt_carry_in;
          if (tmr == '0) begin
            state      <= ST_SETTLE;
            tmr        <= SETTLE_LD;
            cnt_enable <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        // Carry can still arrive through the counter-side synchroniser here.
        ST_SETTLE: begin
          sticky_ovf <= sticky_ovf | cnt_carry_in;
          if (tmr == '0) begin
            state <= ST_LATCH;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_LATCH: begin
          digits_out <= sat_digits(cnt_digits_in, sticky_ovf);
          overflow   <= sticky_ovf;
          state      <= ST_SEND;
        end

        // The streamer holds ready until it is written, so the strobe that
        // appears the cycle after ready is seen still meets a ready streamer.
        ST_SEND: begin
          if (ready_in) begin
            write_stb <= 1'b1;
            if (HOLDOFF_CYCLES > 0) begin
              state <= ST_HOLDOFF;
              tmr   <= HOLD_LD;
            end else if (run_in) begin
              state      <= ST_CLEAR;
              tmr        <= CLEAR_LD;
              sticky_ovf <= 1'b0;
              cnt_reset  <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              cnt_reset <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        ST_HOLDOFF: begin
          if (tmr == '0) begin
            if (run_in) begin
              state      <= ST_CLEAR;
              tmr        <= CLEAR_LD;
              sticky_ovf <= 1'b0;
              cnt_reset  <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              cnt_reset <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          cnt_reset  <= 1'b1;
          cnt_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Bench for freq_meas_sequencer: BCD counter model, scoreboard of expected
// results popped on each write strobe, plus directed timing checks.
module tb_freq_meas_sequencer;

  localparam int DIG  = 6;
  localparam int GATE = 10;
  localparam int CLR  = 2;
  localparam int SET  = 3;
  localparam int HOLD = 5;

  logic          clk_in        = 1'b0;
  logic          reset_in      = 1'b1;
  logic          run_in        = 1'b0;
  logic          single_stb_in = 1'b0;
  logic          ready_in      = 1'b1;
  logic [23:0]   cnt_digits_in;
  logic          cnt_carry_in;
  logic          cnt_reset;
  logic          cnt_enable;
  logic [23:0]   digits_out;
  logic          overflow;
  logic          write_stb;
  logic          busy;

  always #5 clk_in = ~clk_in;

  freq_meas_sequencer #(
    .DIGITS_NUM    (DIG),
    .GATE_CYCLES   (GATE),
    .CLEAR_CYCLES  (CLR),
    .SETTLE_CYCLES (SET),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .run_in        (run_in),
    .single_stb_in (single_stb_in),
    .cnt_digits_in (cnt_digits_in),
    .cnt_carry_in  (cnt_carry_in),
    .ready_in      (ready_in),
    .cnt_reset     (cnt_reset),
    .cnt_enable    (cnt_enable),
    .digits_out    (digits_out),
    .overflow      (overflow),
    .write_stb     (write_stb),
    .busy          (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Counter model: over one gate it accumulates exactly the target count.
  int   cnt_val = 0;
  int   k       = 0;
  int   q_inc   = 0;
  int   r_inc   = 0;
  logic carry_req = 1'b0;

  always @(posedge clk_in) begin
    if (cnt_reset) begin
      cnt_val <= 0;
      k       <= 0;
    end else if (cnt_enable) begin
      cnt_val <= cnt_val + q_inc + ((k < r_inc) ? 1 : 0);
      k       <= k + 1;
    end
  end

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] res;
    int          x;
    res = '0;
    x   = v;
    for (int i = 0; i < DIG; i++) begin
      res[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  assign cnt_digits_in = to_bcd(cnt_val);
  assign cnt_carry_in  = carry_req && cnt_enable && (k == 3);

  task automatic set_target(input int t);
    q_inc = t / GATE;
    r_inc = t % GATE;
  endtask

  // Scoreboard entries: {overflow, digits}
  logic [24:0] exp_q[$];
  logic [24:0] e;

  int   cyc      = 0;
  int   n_stb    = 0;
  int   en_len   = 0;
  int   stb_cyc  = 0;
  logic prev_en  = 1'b0;
  logic prev_stb = 1'b0;
  logic prev_rst = 1'b1;
  logic stb_pend = 1'b0;

  // Output monitor, sampled just after each rising edge.
  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (reset_in) begin
      en_len   = 0;
      prev_en  = 1'b0;
      prev_stb = 1'b0;
      prev_rst = 1'b1;
      stb_pend = 1'b0;
    end else begin
      if (write_stb) begin
        n_stb++;
        chk("stb_single", 32'(prev_stb), 32'd0);
        chk("stb_ready", 32'(ready_in), 32'd1);
        chk("sb_depth", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("digits", 32'(digits_out), 32'(e[23:0]));
          chk("overflow", 32'(overflow), 32'(e[24]));
        end
        stb_pend = 1'b1;
        stb_cyc  = cyc;
      end
      if (cnt_enable) begin
        en_len++;
      end else if (prev_en) begin
        chk("gate_len", en_len, GATE);
        en_len = 0;
      end
      if (cnt_reset && !prev_rst && stb_pend) begin
        chk("holdoff_gap", cyc - stb_cyc, HOLD);
        stb_pend = 1'b0;
      end
      prev_en  = cnt_enable;
      prev_stb = write_stb;
      prev_rst = cnt_reset;
    end
  end

  task automatic pulse_single();
    @(negedge clk_in);
    single_stb_in = 1'b1;
    @(negedge clk_in);
    single_stb_in = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk_in);
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_en(input int max);
    int n = 0;
    while (!cnt_enable && n < max) begin
      @(negedge clk_in);
      n++;
    end
    chk("en_wait", 32'(cnt_enable), 32'd1);
  endtask

  task automatic wait_en_fall(input int max);
    int n = 0;
    while (cnt_enable && n < max) begin
      @(negedge clk_in);
      n++;
    end
    chk("en_fall", 32'(cnt_enable), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int lat;
    int n;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_cnt_reset", 32'(cnt_reset), 32'd1);
    chk("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write_stb", 32'(write_stb), 32'd0);
    chk("rst_digits", 32'(digits_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset_in = 1'b0;

    // Single measurement of 123, streamer ready throughout
    set_target(123);
    exp_q.push_back({1'b0, 24'h000123});
    pulse_single();
    chk("trig_busy", 32'(busy), 32'd1);
    chk("trig_clr", 32'(cnt_reset), 32'd1);
    lat = 1;
    while (!cnt_enable && lat < 20) begin
      @(negedge clk_in);
      lat++;
    end
    chk("trig_lat", lat, CLR + 1);
    chk("gate_clr_low", 32'(cnt_reset), 32'd0);
    wait_idle(100);
    chk("a_stb_cnt", n_stb, 1);

    // Streamer not ready for 20 cycles after the latch
    base     = n_stb;
    ready_in = 1'b0;
    set_target(4567);
    exp_q.push_back({1'b0, 24'h004567});
    pulse_single();
    wait_en(20);
    wait_en_fall(20);
    repeat (SET) @(negedge clk_in);
    chk("latch_hold", 32'(digits_out), 32'h000123);
    @(negedge clk_in);
    chk("latch_new", 32'(digits_out), 32'h004567);
    repeat (20) @(negedge clk_in);
    chk("ready_wait_stb", n_stb, base);
    chk("ready_wait_busy", 32'(busy), 32'd1);
    ready_in = 1'b1;
    wait_idle(20);
    chk("b_stb_cnt", n_stb, base + 1);

    // Carry during the gate, then a clean measurement
    base      = n_stb;
    carry_req = 1'b1;
    set_target(50);
    exp_q.push_back({1'b1, 24'h999999});
    pulse_single();
    wait_idle(100);
    carry_req = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    set_target(7);
    exp_q.push_back({1'b0, 24'h000007});
    pulse_single();
    wait_idle(100);
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("c_stb_cnt", n_stb, base + 2);

    // Continuous run; drop run during the third gate
    base = n_stb;
    set_target(200);
    repeat (3) exp_q.push_back({1'b0, 24'h000200});
    @(negedge clk_in);
    run_in = 1'b1;
    n = 0;
    while (n_stb < base + 2 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("run_two", n_stb, base + 2);
    wait_en(40);
    repeat (3) @(negedge clk_in);
    run_in = 1'b0;
    wait_idle(100);
    chk("run_stop", n_stb, base + 3);
    repeat (10) @(negedge clk_in);
    chk("run_stay_idle", 32'(busy), 32'd0);

    // Single strobe during the gate is ignored
    base = n_stb;
    set_target(9);
    exp_q.push_back({1'b0, 24'h000009});
    pulse_single();
    wait_en(20);
    repeat (2) @(negedge clk_in);
    pulse_single();
    wait_idle(100);
    repeat (30) @(negedge clk_in);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_stb", n_stb, base + 1);

    // Reset in the middle of a gate aborts the measurement
    base = n_stb;
    set_target(300);
    exp_q.push_back({1'b0, 24'h000300});
    pulse_single();
    wait_en(20);
    repeat (4) @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    chk("abort_cnt_reset", 32'(cnt_reset), 32'd1);
    chk("abort_cnt_enable", 32'(cnt_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_write_stb", 32'(write_stb), 32'd0);
    chk("abort_digits", 32'(digits_out), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    repeat (40) @(negedge clk_in);
    chk("abort_no_stb", n_stb, base);
    chk("abort_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
